// File: rtl/arb_mux4_pkg.sv
// Shared types and constants for the four-channel round-robin arbiter/mux.
// Used by arb_mux4, its handshake interface and the rr_pick4 picker.
package arb_mux4_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  typedef logic [SELW-1:0] chan_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Channel index arithmetic wraps naturally at NCH because chan_t is SELW bits wide.
  function automatic chan_t next_chan(input chan_t c);
    return chan_t'(c + chan_t'(1));
  endfunction

endpackage

// File: rtl/arb_mux4_if.sv
// Handshake bundle for arb_mux4: four upstream valid/ready channels plus the
// registered downstream word. The slave modport is the arbiter's view.
interface arb_mux4_if #(parameter int N = 4) ();
  import arb_mux4_pkg::*;

  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [N-1:0]   in0;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic [N-1:0]   in3;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  chan_t          out_sel;

  modport slave (
    input  in_valid, in0, in1, in2, in3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in0, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/arb_mux4_rr_pick4.sv
// Combinational round-robin picker: first valid channel at or after ptr,
// wrapping modulo four.
module rr_pick4
  import arb_mux4_pkg::*;
(
  input  logic [NCH-1:0] i_in_valid,
  input  chan_t          i_ptr,
  output logic           o_gnt_any,
  output chan_t          o_gnt_idx
);

  // Scan from the farthest offset back to ptr so the nearest valid channel wins.
  always_comb begin
    chan_t w_cand;
    o_gnt_any = |i_in_valid;
    o_gnt_idx = i_ptr;
    w_cand    = i_ptr;
    for (int off = NCH - 1; off >= 0; off--) begin
      w_cand = chan_t'(i_ptr + chan_t'(off));
      if (i_in_valid[w_cand]) begin
        o_gnt_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux4.sv
// Four-channel round-robin arbiter feeding a single registered output word.
// Define ARB_LOCK_EN to add the lock input that holds the grant on the last winner.
module arb_mux4
  import arb_mux4_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ARB_LOCK_EN
  input  logic lock,
`endif
  arb_mux4_if.slave bus
);

  state_t         r_state;
  state_t         w_nextState;
  chan_t          r_ptr;
  chan_t          r_outSel;
  logic [N-1:0]   r_outData;
  logic [N-1:0]   w_muxData;
  logic           w_loadOk;
  logic           w_pickAny;
  chan_t          w_pickIdx;
  chan_t          w_gntIdx;
  logic           w_grant;

  // rst_n gates loading so no channel sees in_ready while reset is held.
  assign w_loadOk = rst_n & ((r_state == EMPTY) | bus.out_ready);
  assign w_grant  = w_loadOk & w_pickAny;

  rr_pick4 u_pick (
    .i_in_valid (bus.in_valid),
    .i_ptr      (r_ptr),
    .o_gnt_any  (w_pickAny),
    .o_gnt_idx  (w_pickIdx)
  );

`ifdef ARB_LOCK_EN
  chan_t r_lastG;

  assign w_gntIdx = (lock && bus.in_valid[r_lastG]) ? r_lastG : w_pickIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastG <= '0;
    end else if (w_grant) begin
      r_lastG <= w_gntIdx;
    end
  end
`else
  assign w_gntIdx = w_pickIdx;
`endif

  always_comb begin
    bus.in_ready = '0;
    if (w_grant) begin
      bus.in_ready[w_gntIdx] = 1'b1;
    end
  end

  always_comb begin
    w_muxData = bus.in0;
    case (w_gntIdx)
      2'd0:    w_muxData = bus.in0;
      2'd1:    w_muxData = bus.in1;
      2'd2:    w_muxData = bus.in2;
      2'd3:    w_muxData = bus.in3;
      default: w_muxData = bus.in0;
    endcase
  end

  // A grant always refills the register, even while the old word drains.
  always_comb begin
    w_nextState = r_state;
    if (w_grant) begin
      w_nextState = FULL;
    end else if (bus.out_ready) begin
      w_nextState = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData <= '0;
      r_outSel  <= '0;
      r_ptr     <= '0;
    end else if (w_grant) begin
      r_outData <= w_muxData;
      r_outSel  <= w_gntIdx;
      r_ptr     <= next_chan(w_gntIdx);
    end
  end

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_outData;
  assign bus.out_sel   = r_outSel;

endmodule

// File: tb/tb_arb_mux4.sv
// Randomised scoreboard bench for arb_mux4; the stimulus side predicts grants from
// a plain round-robin model and queues expected words, a monitor checks delivery.
module tb_arb_mux4;
  import arb_mux4_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] data;
    int           sel;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
`ifdef ARB_LOCK_EN
  logic lock;
`endif

  word_t expQ[$];
  int    mPtr;
  int    mLastG;
  bit    mFull;
  int    nVectors    = 0;
  int    nMiscompares = 0;

  always #5 clk = ~clk;

  arb_mux4_if #(.N(N)) bus ();

  arb_mux4 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the edge, predict the grant from the model, queue the word.
  task automatic applyStimulus(input logic [3:0] iv, input logic rdy, input logic lk,
                               input logic [15:0] dat);
    int         g;
    logic [3:0] expReady;
    word_t      w;
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.out_ready = rdy;
    {bus.in3, bus.in2, bus.in1, bus.in0} = dat;
`ifdef ARB_LOCK_EN
    lock = lk;
`endif
    #1;
    checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, mFull});
    g = -1;
    if ((!mFull || rdy) && iv != 4'd0) begin
      for (int off = 0; off < 4; off++) begin
        if (g < 0 && iv[(mPtr + off) % 4]) g = (mPtr + off) % 4;
      end
`ifdef ARB_LOCK_EN
      if (lk && iv[mLastG]) g = mLastG;
`endif
    end
    expReady = (g >= 0) ? 4'(1 << g) : 4'b0000;
    checkOutput("in_ready", {28'd0, bus.in_ready}, {28'd0, expReady});
    if (g >= 0) begin
      w.data = dat[g*4 +: 4];
      w.sel  = g;
      expQ.push_back(w);
      mPtr   = (g + 1) % 4;
      mLastG = g;
      mFull  = 1'b1;
    end else if (rdy) begin
      mFull = 1'b0;
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    checkOutput("out_valid before reset", {31'd0, bus.out_valid}, {31'd0, mFull});
    rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset out_data", {28'd0, bus.out_data}, 32'd0);
    checkOutput("reset out_sel", {30'd0, bus.out_sel}, 32'd0);
    checkOutput("reset in_ready", {28'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 4'd0;
    expQ.delete();
    mPtr   = 0;
    mLastG = 0;
    mFull  = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: the head of the queue is always the word currently in the register.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        checkOutput("word expected", {31'd0, expQ.size() > 0}, 32'd1);
        if (expQ.size() > 0) begin
          checkOutput("out_data", {28'd0, bus.out_data}, {28'd0, expQ[0].data});
          checkOutput("out_sel", {30'd0, bus.out_sel}, expQ[0].sel);
          if (bus.out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'd0;
    bus.out_ready = 1'b0;
    {bus.in3, bus.in2, bus.in1, bus.in0} = 16'h0000;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    mPtr   = 0;
    mLastG = 0;
    mFull  = 1'b0;
    #2;
    checkOutput("init out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("init out_data", {28'd0, bus.out_data}, 32'd0);
    checkOutput("init out_sel", {30'd0, bus.out_sel}, 32'd0);
    checkOutput("init in_ready", {28'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(4'b0100, 1'b1, 1'b0, 16'h0700);
    applyStimulus(4'b0010, 1'b1, 1'b0, 16'h0A50);
    applyStimulus(4'b1000, 1'b1, 1'b0, 16'hC000);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b1, 1'b0, 16'hF731);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0011, 1'b0, 1'b0, 16'h0095);
    applyStimulus(4'b0011, 1'b1, 1'b0, 16'h0095);
    doReset();
    applyStimulus(4'b1111, 1'b1, 1'b0, 16'h4321);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 1'b1, 1'b1, 16'hBEEF);
    applyStimulus(4'b1111, 1'b1, 1'b0, 16'hBEEF);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 16'($urandom));
    end

    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    checkOutput("queue drained", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
